bsg_cgol_input_deser: RTL and testbench

- Upstream stage of the cell-array controller in the encryptor datapath.
- Accepts a narrow stream of words over a valid/ready channel: one header word carrying the game length, followed by the packed initial board.
- Assembles these into a full board_width_p x board_width_p bit image plus a frame count.
- Presents the result to the controller's input channel (v/ready, frames) and to the cell array's initial-state input.

---
 rtl/bsg_cgol_pkg.sv | 23 ++
 rtl/bsg_cgol_frames_clamp.sv | 38 +++
 rtl/bsg_cgol_input_deser.sv | 116 +++++++++++
 tb/tb_bsg_cgol_input_deser.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bsg_cgol_pkg.sv
// Shared types and width helpers for the cellular-automaton encryptor blocks.
package bsg_cgol_pkg;

  typedef enum logic [1:0] {
    eHDR  = 2'd0,
    eDATA = 2'd1,
    eFULL = 2'd2
  } state_e;

  // clog2 that never returns 0, so a 1-entry range still gets a 1-bit field
  function automatic int safe_clog2(input int x);
    if (x <= 1) begin
      return 1;
    end
    return $clog2(x);
  endfunction

  // Width of a frame count able to hold max_len itself
  function automatic int game_len_width(input int max_len);
    return safe_clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/bsg_cgol_frames_clamp.sv
// Converts a raw host header word into a legal frame count in [1, max_game_length_p].
module bsg_cgol_frames_clamp
  import bsg_cgol_pkg::*;
#(
  parameter int data_width_p      = 32,
  parameter int max_game_length_p = 1024
) (
  input  logic [data_width_p-1:0]                      data_i,
  output logic [game_len_width(max_game_length_p)-1:0] frames_o
);

  localparam int game_len_width_lp = game_len_width(max_game_length_p);
  localparam logic [game_len_width_lp-1:0] max_frames_lp =
    game_len_width_lp'(max_game_length_p);

  logic                         upper_nz;
  logic [game_len_width_lp-1:0] field;

  assign field = data_i[game_len_width_lp-1:0];

  // Any bit above the frame field means the host asked for more than we can count
  if (data_width_p > game_len_width_lp) begin : g_upper
    assign upper_nz = |data_i[data_width_p-1:game_len_width_lp];
  end else begin : g_no_upper
    assign upper_nz = 1'b0;
  end

  // Saturate high, and lift zero to one since the controller needs at least one frame
  always_comb begin
    frames_o = field;
    if (upper_nz || (field > max_frames_lp)) begin
      frames_o = max_frames_lp;
    end else if (field == '0) begin
      frames_o = game_len_width_lp'(1);
    end
  end

endmodule

// File: rtl/bsg_cgol_input_deser.sv
// Collects a header word plus the packed initial board from a narrow
// valid/ready stream and presents the full board and frame count downstream.
//
// state | meaning
// eHDR  | waiting for the header word carrying the game length
// eDATA | collecting board words, counter selects the destination slice
// eFULL | board and frames valid, holding until downstream takes them
module bsg_cgol_input_deser
  import bsg_cgol_pkg::*;
#(
  parameter int board_width_p     = 32,
  parameter int max_game_length_p = 1024,
  parameter int data_width_p      = 32
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic                                         v_i,
  input  logic [data_width_p-1:0]                      data_i,
  output logic                                         ready_o,
  output logic                                         v_o,
  input  logic                                         ready_i,
  output logic [game_len_width(max_game_length_p)-1:0] frames_o,
  output logic [board_width_p*board_width_p-1:0]       data_o
);

  localparam int board_bits_lp     = board_width_p * board_width_p;
  localparam int num_words_lp      = (board_bits_lp + data_width_p - 1) / data_width_p;
  localparam int game_len_width_lp = game_len_width(max_game_length_p);
  localparam int cnt_width_lp      = safe_clog2(num_words_lp);
  localparam logic [cnt_width_lp-1:0] last_word_lp = cnt_width_lp'(num_words_lp - 1);

  state_e                        state_q, state_d;
  logic [cnt_width_lp-1:0]       cnt_q, cnt_d;
  logic [game_len_width_lp-1:0]  frames_q, frames_d;
  logic [board_bits_lp-1:0]      board_q, board_d;
  logic [game_len_width_lp-1:0]  frames_clamped;
  logic                          in_fire;
  logic                          out_fire;

  bsg_cgol_frames_clamp #(
    .data_width_p      (data_width_p),
    .max_game_length_p (max_game_length_p)
  ) u_clamp (
    .data_i   (data_i),
    .frames_o (frames_clamped)
  );

  // Handshake outputs are forced low while reset is held, whatever the stale state
  assign ready_o  = ~reset_i & (state_q != eFULL);
  assign v_o      = ~reset_i & (state_q == eFULL);
  assign in_fire  = v_i & ready_o;
  assign out_fire = v_o & ready_i;

  assign frames_o = frames_q;
  assign data_o   = board_q;

  // Next-state, counter and datapath capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    frames_d = frames_q;
    board_d  = board_q;
    unique case (state_q)
      eHDR: begin
        if (in_fire) begin
          frames_d = frames_clamped;
          cnt_d    = '0;
          state_d  = eDATA;
        end
      end
      eDATA: begin
        if (in_fire) begin
          // Bits of the last word beyond the board simply have no destination
          for (int i = 0; i < board_bits_lp; i++) begin
            if (int'(cnt_q) == (i / data_width_p)) begin
              board_d[i] = data_i[i % data_width_p];
            end
          end
          if (cnt_q == last_word_lp) begin
            cnt_d   = '0;
            state_d = eFULL;
          end else begin
            cnt_d = cnt_q + cnt_width_lp'(1);
          end
        end
      end
      eFULL: begin
        if (out_fire) begin
          state_d = eHDR;
        end
      end
      default: begin
        state_d = eHDR;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eHDR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Board and frames carry no reset; they only matter while v_o is high
  always_ff @(posedge clk_i) begin
    frames_q <= frames_d;
    board_q  <= board_d;
  end

endmodule

// File: tb/tb_bsg_cgol_input_deser.sv
module tb_bsg_cgol_input_deser;

  localparam int BW   = 4;
  localparam int DW   = 8;
  localparam int MAXG = 10;
  localparam int NW   = 2;
  localparam int BB   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i, v_i, ready_i, ready_o, v_o;
  logic [DW-1:0] data_i;
  logic [3:0]    frames_o;
  logic [BB-1:0] data_o;

  logic       reset2, v2, ready2_i, ready2_o, v2_o;
  logic [3:0] d2;
  logic [3:0] frames2;
  logic [8:0] data2;

  bsg_cgol_input_deser #(.board_width_p(BW), .max_game_length_p(MAXG), .data_width_p(DW)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .v_o(v_o), .ready_i(ready_i), .frames_o(frames_o), .data_o(data_o));

  bsg_cgol_input_deser #(.board_width_p(3), .max_game_length_p(10), .data_width_p(4)) dut2 (
    .clk_i(clk), .reset_i(reset2), .v_i(v2), .data_i(d2), .ready_o(ready2_o),
    .v_o(v2_o), .ready_i(ready2_i), .frames_o(frames2), .data_o(data2));

  int checks = 0;
  int errors = 0;

  // Reference model: number of words accepted in the current game
  // (0 = nothing yet, 1 = header taken, NW+1 = board complete)
  int            taken = 0;
  int            frames_m = 0;
  logic [BB-1:0] board_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_ref(input int val);
    if (val == 0) return 1;
    if (val > MAXG) return MAXG;
    return val;
  endfunction

  task automatic step(input bit v, input logic [DW-1:0] d, input bit rdy, input bit rst);
    bit exp_rdy, exp_v;
    v_i = v; data_i = d; ready_i = rdy; reset_i = rst;
    @(posedge clk);
    if (rst) begin
      taken = 0;
    end else begin
      exp_rdy = (taken <= NW);
      exp_v   = (taken == NW + 1);
      if (v && exp_rdy) begin
        if (taken == 0) frames_m = clamp_ref(int'(d));
        else board_m[(taken-1)*DW +: DW] = d;
        taken++;
      end
      if (exp_v && rdy) taken = 0;
    end
    @(negedge clk);
    exp_rdy = !rst && (taken <= NW);
    exp_v   = !rst && (taken == NW + 1);
    chk("ready_o", 32'(ready_o), 32'(exp_rdy));
    chk("v_o", 32'(v_o), 32'(exp_v));
    if (exp_v) begin
      chk("data_o", 32'(data_o), 32'(board_m));
      chk("frames_o", 32'(frames_o), 32'(frames_m));
    end
  endtask

  task automatic game(input logic [DW-1:0] hdr, input logic [DW-1:0] w0,
                      input logic [DW-1:0] w1, input int gap);
    step(1'b1, hdr, 1'b0, 1'b0);
    for (int g = 0; g < gap; g++) step(1'b0, 8'h77, 1'b0, 1'b0);
    step(1'b1, w0, 1'b0, 1'b0);
    for (int g = 0; g < gap; g++) step(1'b0, 8'h99, 1'b0, 1'b0);
    step(1'b1, w1, 1'b0, 1'b0);
  endtask

  task automatic handoff();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("handoff_v", 32'(v_o), 32'd0);
    chk("handoff_ready", 32'(ready_o), 32'd1);
  endtask

  task automatic step2(input bit v, input logic [3:0] d, input bit rst);
    v2 = v; d2 = d; reset2 = rst;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    v2 = 1'b0; d2 = '0; ready2_i = 1'b0; reset2 = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("reset_ready", 32'(ready_o), 32'd0);
    chk("reset_v", 32'(v_o), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle_ready", 32'(ready_o), 32'd1);

    // Back-to-back load
    step(1'b1, 8'h05, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("b2b_v_before_last", 32'(v_o), 32'd0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("b2b_v", 32'(v_o), 32'd1);
    chk("b2b_data", 32'(data_o), 32'h3CA5);
    chk("b2b_frames", 32'(frames_o), 32'd5);
    chk("b2b_ready", 32'(ready_o), 32'd0);

    // Backpressure with ignored v_i pulses
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      chk("hold_data", 32'(data_o), 32'h3CA5);
      chk("hold_frames", 32'(frames_o), 32'd5);
      chk("hold_ready", 32'(ready_o), 32'd0);
    end
    handoff();

    // Second game
    game(8'h02, 8'hFF, 8'h00, 0);
    chk("g2_data", 32'(data_o), 32'h00FF);
    chk("g2_frames", 32'(frames_o), 32'd2);
    handoff();

    // Clamping
    game(8'h00, 8'h12, 8'h34, 0);
    chk("clamp_zero", 32'(frames_o), 32'd1);
    handoff();
    game(8'h0F, 8'h12, 8'h34, 0);
    chk("clamp_0f", 32'(frames_o), 32'd10);
    handoff();
    game(8'h12, 8'h12, 8'h34, 0);
    chk("clamp_upper", 32'(frames_o), 32'd10);
    chk("clamp_upper_data", 32'(data_o), 32'h3412);
    handoff();
    game(8'h0A, 8'h00, 8'h00, 0);
    chk("clamp_exact_max", 32'(frames_o), 32'd10);
    handoff();

    // Bubbles
    game(8'h05, 8'hA5, 8'h3C, 3);
    chk("bubble_data", 32'(data_o), 32'h3CA5);
    chk("bubble_frames", 32'(frames_o), 32'd5);
    handoff();

    // Reset mid-game
    step(1'b1, 8'h07, 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    chk("midreset_ready", 32'(ready_o), 32'd0);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    game(8'h03, 8'h5A, 8'hC3, 0);
    chk("after_reset_data", 32'(data_o), 32'hC35A);
    chk("after_reset_frames", 32'(frames_o), 32'd3);
    handoff();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [DW-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      step($urandom_range(0, 9) < 7, d, $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
    end

    // Truncating configuration: 9-bit board from three 4-bit words
    step2(1'b0, 4'h0, 1'b1);
    step2(1'b0, 4'h0, 1'b1);
    step2(1'b0, 4'h0, 1'b0);
    chk("trunc_ready_idle", 32'(ready2_o), 32'd1);
    step2(1'b1, 4'h3, 1'b0);
    step2(1'b1, 4'hF, 1'b0);
    step2(1'b1, 4'hF, 1'b0);
    chk("trunc_v_before_last", 32'(v2_o), 32'd0);
    step2(1'b1, 4'hF, 1'b0);
    chk("trunc_v", 32'(v2_o), 32'd1);
    chk("trunc_data", 32'(data2), 32'h1FF);
    chk("trunc_frames", 32'(frames2), 32'd3);
    chk("trunc_ready_full", 32'(ready2_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
